bcd_seg_scan: RTL and testbench
===============================

// Module: bcd_seg_scan
// PURPOSE
//  Consumes the sign+BCD word from bin2bcd and drives a 5-position multiplexed 7-segment display
//  (sign, thousands, hundreds, tens, units). Time-multiplexes the digits using a programmable
//  slot timer with inter-digit ghost blanking, applies leading-zero blanking, and swaps in new
//  values only at frame boundaries so a frame never shows a mix of two values.
// PARAMETERS
//  DIV          50000  clocks per digit slot; must be > BLANK_CYC
//  BLANK_CYC    4      leading clocks of each slot with all digits off (0 = no ghost blanking)
//  SEG_ACT_LOW  1      1: seg outputs active-low; 0: active-high
//  DIG_ACT_LOW  1      1: dig outputs active-low; 0: active-high
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-high
//  bcd         in   17  {sign, thou[3:0], hund[3:0], tens[3:0], units[3:0]}
//  bcd_vld     in   1   1-cycle strobe; bcd is valid in that cycle
//  seg         out  8   {dp,g,f,e,d,c,b,a}; dp is always off
//  dig         out  5   one-hot digit enable: [0]=units, [1]=tens, [2]=hund, [3]=thou, [4]=sign
//  frame_done  out  1   1-cycle pulse on the last clock of the sign slot
// BEHAVIOUR
//  - Reset: slot counter cnt=0, digit index idx=0, display register disp=0, pending register
//    cleared. seg and dig are at their inactive levels; frame_done=0.
//  - Capture: on bcd_vld, bcd is stored into pend and pend_flag is set. If several strobes occur
//    within one frame, the last one wins.
//  - Frame swap: at cnt==DIV-1 && idx==4, disp loads pend if pend_flag is set, and pend_flag is
//    cleared. If bcd_vld is asserted in that same cycle, disp loads bcd directly.
//  - Timer: cnt counts 0..DIV-1, then wraps to 0 and increments idx. idx counts 0..4, then wraps
//    to 0.
//  - Slot: for cnt<BLANK_CYC, all digits are off. For cnt>=BLANK_CYC, dig[idx] is active,
//    unless that position is blanked.
//  - seg and dig are registered: the output at cycle t reflects cnt/idx/disp at cycle t-1.
//  - Leading-zero blanking:
//      thou is blanked if thou==0.
//      hund is blanked if thou==0 && hund==0.
//      tens is blanked if thou, hund and tens are all 0.
//      units is never blanked.
//  - Sign position: shows minus (g only) when sign=1. When sign=0 it is blanked, which makes -0
//    display as "-0".
//  - Blanked position: its dig line stays inactive and seg stays inactive for the whole slot.
//  - Segment code (gfedcba, active-high form):
//      0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, minus=40.
//      Nibble values A-F display 'E'=79.
//      Invert per SEG_ACT_LOW.
//  - frame_done: asserted (registered) in the cycle after cnt==DIV-1 && idx==4.
//  - Reset mid-slot: the cycle after rst is sampled high, all outputs are inactive and all state
//    equals the reset values. The scan restarts at units.
// TESTING (DIV=8, BLANK_CYC=2, SEG_ACT_LOW=0, DIG_ACT_LOW=0)
//  1. Release reset, no bcd_vld:
//     - slot 0: dig=00001 with seg=3F for 6 of its 8 cycles.
//     - slots 1-4: dig=00000, seg=00.
//     - frame_done pulses once every 40 cycles.
//  2. bcd=17'h01234 + vld, then wait for frame_done:
//     - next frame shows units 66, tens 4F, hund 5B, thou 06.
//     - sign slot is blank.
//  3. bcd={1'b1,16'h0045}:
//     - units 6D, tens 66.
//     - hund and thou are blank (dig off).
//     - dig[4] active with seg=40.
//  4. vld with 17'h00007 mid-frame while 1234 is displayed:
//     - rest of the frame still shows 1234.
//     - from the frame after frame_done, only units=07 is shown.
//     - repeat with vld in the swap cycle: the new value appears in the immediately following frame.
//  5. bcd=17'h0A0B0:
//     - units 3F, tens 79, hund 3F, thou 79 (no blanking, since thou!=0).
//  6. Assert rst at cnt=5 of the tens slot:
//     - next cycle: seg=00, dig=00000, frame_done=0.
//     - after release, the scan restarts at units showing 0 (3F).

Source files
------------

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
//   Scans a sign+BCD word onto a 5-position multiplexed 7-segment display
//   (sign, thousands, hundreds, tens, units). Each digit owns a slot of DIV
//   clocks. The first BLANK_CYC clocks of every slot keep all digits dark to
//   hide ghosting. Leading zeros are blanked. A new value is only taken into
//   the display register at the end of a frame, so no frame ever mixes two
//   values.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   bcd         {sign, thou[3:0], hund[3:0], tens[3:0], units[3:0]}
//   bcd_vld     1-cycle strobe qualifying bcd
//   seg         {dp,g,f,e,d,c,b,a}, dp always off, polarity per SEG_ACT_LOW
//   dig         one-hot digit enable [0]=units .. [4]=sign, polarity per DIG_ACT_LOW
//   frame_done  1-cycle pulse on the last clock of the sign slot
module bcd_seg_scan #(
   parameter int DIV         = 50000,
   parameter int BLANK_CYC   = 4,
   parameter int SEG_ACT_LOW = 1,
   parameter int DIG_ACT_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [16:0] bcd,
   input  logic        bcd_vld,
   output logic [7:0]  seg,
   output logic [4:0]  dig,
   output logic        frame_done
);

   localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYC);
   // XOR masks: an all-zero active-high pattern maps to the inactive level
   localparam logic [7:0]     SEG_MASK  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [4:0]     DIG_MASK  = (DIG_ACT_LOW != 0) ? 5'h1F : 5'h00;

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [16:0]   disp;
   logic [16:0]   pend;
   logic          pend_flag;

   logic          slot_end;
   logic          frame_end;
   logic          thou_z, hund_z, tens_z;
   logic [3:0]    nib;
   logic          show;
   logic          minus;
   logic [6:0]    code;
   logic          lit;
   logic [7:0]    seg_nxt;
   logic [4:0]    dig_nxt;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == 3'd4);

   assign thou_z = (disp[15:12] == 4'h0);
   assign hund_z = (disp[11:8]  == 4'h0);
   assign tens_z = (disp[7:4]   == 4'h0);

   always_comb begin
      nib   = 4'h0;
      show  = 1'b0;
      minus = 1'b0;
      case (idx)
         3'd0: begin nib = disp[3:0];   show = 1'b1; end
         3'd1: begin nib = disp[7:4];   show = !(thou_z && hund_z && tens_z); end
         3'd2: begin nib = disp[11:8];  show = !(thou_z && hund_z); end
         3'd3: begin nib = disp[15:12]; show = !thou_z; end
         3'd4: begin minus = 1'b1;      show = disp[16]; end
         default: ;
      endcase
   end

   always_comb begin
      case (nib)
         4'd0:    code = 7'h3F;
         4'd1:    code = 7'h06;
         4'd2:    code = 7'h5B;
         4'd3:    code = 7'h4F;
         4'd4:    code = 7'h66;
         4'd5:    code = 7'h6D;
         4'd6:    code = 7'h7D;
         4'd7:    code = 7'h07;
         4'd8:    code = 7'h7F;
         4'd9:    code = 7'h6F;
         default: code = 7'h79;   // non-decimal nibble shows 'E'
      endcase
      if (minus) code = 7'h40;
   end

   always_comb begin
      lit     = show && (cnt >= CNT_BLANK);
      seg_nxt = lit ? {1'b0, code} : 8'h00;
      dig_nxt = lit ? (5'b00001 << idx) : 5'b00000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= 3'd0;
         disp       <= '0;
         pend       <= '0;
         pend_flag  <= 1'b0;
         seg        <= SEG_MASK;
         dig        <= DIG_MASK;
         frame_done <= 1'b0;
      end else begin
         if (slot_end) begin
            cnt <= '0;
            idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end

         // A strobe landing on the swap cycle bypasses pend so it is not
         // deferred by a whole frame.
         if (frame_end) begin
            if (bcd_vld)        disp <= bcd;
            else if (pend_flag) disp <= pend;
            pend_flag <= 1'b0;
         end else if (bcd_vld) begin
            pend      <= bcd;
            pend_flag <= 1'b1;
         end

         seg        <= seg_nxt ^ SEG_MASK;
         dig        <= dig_nxt ^ DIG_MASK;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;

   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRAME = 5 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] bcd = '0;
   logic        bcd_vld = 1'b0;
   logic [7:0]  seg;
   logic [4:0]  dig;
   logic        frame_done;

   bcd_seg_scan #(
      .DIV(DIV), .BLANK_CYC(BLANK), .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)
   ) dut (
      .clk(clk), .rst(rst), .bcd(bcd), .bcd_vld(bcd_vld),
      .seg(seg), .dig(dig), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int fd_cnt;
   string phase = "init";

   // reference model: time since reset plus displayed/pending values
   int          mcyc = 0;
   logic [16:0] mdisp = '0;
   logic [16:0] mpend = '0;
   logic        mpend_v = 1'b0;
   logic [7:0]  seg_tab [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s/%s got=%h exp=%h t=%0t", phase, tag, got, exp, $time);
      end
   endtask

   // expected {frame_done, dig, seg} for the cycle after frame position pos
   function automatic logic [13:0] exp_out(input int pos, input logic [16:0] d);
      int slot, sub;
      logic show;
      logic [7:0] s;
      logic [3:0] n;
      slot = pos / DIV;
      sub  = pos % DIV;
      show = 1'b0;
      s    = 8'h00;
      if (slot == 4) begin
         show = d[16];
         s    = 8'h40;
      end else begin
         n    = d[4*slot +: 4];
         // a digit is shown if it or anything more significant is non-zero
         show = (slot == 0) || ((d[15:0] >> (4*slot)) != 16'h0);
         s    = seg_tab[n];
      end
      if (sub < BLANK) show = 1'b0;
      return {(pos == FRAME - 1), (show ? 5'(1 << slot) : 5'b0), (show ? s : 8'h00)};
   endfunction

   task automatic step(input logic v, input logic [16:0] b, input logic r);
      logic [13:0] e;
      int pos;
      pos = mcyc % FRAME;
      e = r ? 14'h0 : exp_out(pos, mdisp);
      bcd_vld = v; bcd = b; rst = r;
      @(posedge clk); #1;
      check("out", 32'({frame_done, dig, seg}), 32'(e));
      if (frame_done) fd_cnt++;
      if (r) begin
         mcyc = 0; mdisp = '0; mpend = '0; mpend_v = 1'b0;
      end else begin
         if (pos == FRAME - 1) begin
            if (v) mdisp = b;
            else if (mpend_v) mdisp = mpend;
            mpend_v = 1'b0;
         end else if (v) begin
            mpend = b; mpend_v = 1'b1;
         end
         mcyc++;
      end
      bcd_vld = 1'b0; rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   task automatic to_pos(input int p);
      for (int i = 0; i < FRAME && (mcyc % FRAME) != p; i++) step(1'b0, '0, 1'b0);
   endtask

   initial begin
      seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                  8'h7F, 8'h6F, 8'h79, 8'h79, 8'h79, 8'h79, 8'h79, 8'h79};

      phase = "reset";
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      check("rst_seg", 32'(seg), 32'h00);
      check("rst_dig", 32'(dig), 32'h00);

      phase = "idle";
      fd_cnt = 0;
      idle(2);
      check("blank_lead", 32'(dig), 32'h00);
      step(1'b0, '0, 1'b0);
      check("units_seg", 32'(seg), 32'h3F);
      check("units_dig", 32'(dig), 32'h01);
      idle(2 * FRAME - 3);
      check("fd_per_2frames", 32'(fd_cnt), 32'd2);

      phase = "v1234";
      step(1'b1, 17'h01234, 1'b0);
      idle(2 * FRAME);

      phase = "neg45";
      step(1'b1, {1'b1, 16'h0045}, 1'b0);
      idle(2 * FRAME);

      phase = "midframe";
      step(1'b1, 17'h01234, 1'b0);
      idle(2 * FRAME);
      to_pos(15);
      step(1'b1, 17'h00007, 1'b0);
      idle(2 * FRAME);

      phase = "swapcycle";
      step(1'b1, 17'h01234, 1'b0);
      idle(FRAME);
      to_pos(FRAME - 1);
      step(1'b1, 17'h00007, 1'b0);
      idle(DIV - 1);
      check("swap_units", 32'(seg), 32'h07);
      idle(FRAME);

      phase = "hexnib";
      step(1'b1, 17'h0A0B0, 1'b0);
      idle(2 * FRAME);

      phase = "neg0";
      step(1'b1, {1'b1, 16'h0000}, 1'b0);
      idle(2 * FRAME);

      phase = "random";
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) step(1'b1, 17'($urandom), 1'b0);
         else step(1'b0, '0, 1'b0);
      end

      phase = "midreset";
      step(1'b1, 17'h01234, 1'b0);
      idle(2 * FRAME);
      to_pos(DIV + 5);
      step(1'b0, '0, 1'b1);
      check("mr_seg", 32'(seg), 32'h00);
      check("mr_dig", 32'(dig), 32'h00);
      check("mr_fd", 32'(frame_done), 32'h0);
      idle(BLANK + 1);
      check("mr_units_seg", 32'(seg), 32'h3F);
      check("mr_units_dig", 32'(dig), 32'h01);
      idle(FRAME);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
